// File: rtl/msdap_main_controller_if.sv
// Bundles the sample input and the memory/ALU control outputs of the MSDAP sequencer.
// No latency of its own; the slave side (controller) registers every output.
// Backpressure is advisory only: the source should honour InReady, and words offered while it is low are dropped.
interface msdap_main_controller_if;
  // sample words from the serial-to-parallel front end
  logic        s2p_valid;
  logic [15:0] dataL;
  logic [15:0] dataR;
  logic        InReady;
  // memory write ports (shared by both channels)
  logic        rj_we;
  logic [3:0]  rj_waddr;
  logic        coeff_we;
  logic [8:0]  coeff_waddr;
  logic        in_we;
  logic [7:0]  in_waddr;
  logic [15:0] wdataL;
  logic [15:0] wdataR;
  // ALU controller control
  logic        work_enable;
  logic        Clear;
  logic        sleep_flag;

  // master: the sample source / environment
  modport master (
    output s2p_valid, dataL, dataR,
    input  InReady, rj_we, rj_waddr, coeff_we, coeff_waddr, in_we, in_waddr,
           wdataL, wdataR, work_enable, Clear, sleep_flag
  );

  // slave: the main controller
  modport slave (
    input  s2p_valid, dataL, dataR,
    output InReady, rj_we, rj_waddr, coeff_we, coeff_waddr, in_we, in_waddr,
           wdataL, wdataR, work_enable, Clear, sleep_flag
  );
endinterface

// File: rtl/msdap_main_controller.sv
// MSDAP top-level sequencer: loads Rj/coeff/input memories, clears input memory, drives ALU start/clear/sleep.
// Latency: write strobe/addr/data 1 cycle after s2p_valid, work_enable 2 cycles after; INIT/CLEAR take 256 cycles.
// Backpressure: InReady low in INIT/CLEAR, where strobes are dropped; zero samples are discarded while asleep.
module msdap_main_controller #(
  parameter int ZERO_LIMIT = 800
) (
  input logic                     Sclk,
  input logic                     Clear_n,
  input logic                     Reset_in_n,
  msdap_main_controller_if.slave  bus
);

  localparam logic [3:0] INIT       = 4'd0;
  localparam logic [3:0] WAIT_RJ    = 4'd1;
  localparam logic [3:0] READ_RJ    = 4'd2;
  localparam logic [3:0] WAIT_COEFF = 4'd3;
  localparam logic [3:0] READ_COEFF = 4'd4;
  localparam logic [3:0] WAIT_INPUT = 4'd5;
  localparam logic [3:0] WORK       = 4'd6;
  localparam logic [3:0] CLEAR      = 4'd7;
  localparam logic [3:0] SLEEP      = 4'd8;

  localparam logic [9:0] ZLIM = 10'(ZERO_LIMIT);

  logic [3:0] state, state_nxt;
  logic [9:0] zl, zr;
  logic [9:0] zl_upd, zr_upd;
  logic       kick;

  logic       do_in_wr, do_rj, do_coeff, do_kick;
  logic       clr_wr, clr_start, clr_last;
  logic       cnt_upd, cnt_clr;
  logic       sleep_nxt;
  logic       chip_rst, wake;
  logic [3:0] rj_tgt;
  logic [8:0] coeff_tgt;

  // Saturating zero-run counters as they would look after accepting the current words.
  always_comb begin
    zl_upd = 10'd0;
    zr_upd = 10'd0;
    if (bus.dataL == 16'd0) zl_upd = (zl == ZLIM) ? ZLIM : zl + 10'd1;
    if (bus.dataR == 16'd0) zr_upd = (zr == ZLIM) ? ZLIM : zr + 10'd1;
  end

  // Next state and per-cycle actions; the address a strobe will land on includes any write still in flight.
  always_comb begin
    state_nxt = state;
    do_in_wr  = 1'b0;
    do_rj     = 1'b0;
    do_coeff  = 1'b0;
    do_kick   = 1'b0;
    clr_wr    = 1'b0;
    clr_start = 1'b0;
    cnt_upd   = 1'b0;
    cnt_clr   = 1'b0;
    sleep_nxt = bus.sleep_flag;
    rj_tgt    = bus.rj_waddr + {3'd0, bus.rj_we};
    coeff_tgt = bus.coeff_waddr + {8'd0, bus.coeff_we};
    clr_last  = bus.in_we && (bus.in_waddr == 8'hFF);
    chip_rst  = !Reset_in_n &&
                ((state == WAIT_INPUT) || (state == WORK) || (state == SLEEP));
    wake      = bus.s2p_valid && ((bus.dataL != 16'd0) || (bus.dataR != 16'd0));

    case (state)
      INIT, CLEAR: begin
        if (clr_last) begin
          state_nxt = (state == INIT) ? WAIT_RJ : WAIT_INPUT;
          cnt_clr   = 1'b1;
        end else begin
          clr_wr = 1'b1;
        end
      end
      WAIT_RJ, READ_RJ: begin
        if (bus.s2p_valid) begin
          do_rj     = 1'b1;
          state_nxt = (rj_tgt == 4'd15) ? WAIT_COEFF : READ_RJ;
        end
      end
      WAIT_COEFF, READ_COEFF: begin
        if (bus.s2p_valid) begin
          do_coeff  = 1'b1;
          state_nxt = (coeff_tgt == 9'd511) ? WAIT_INPUT : READ_COEFF;
        end
      end
      WAIT_INPUT, WORK: begin
        if (chip_rst) begin
          state_nxt = CLEAR;
          clr_start = 1'b1;
          cnt_clr   = 1'b1;
          sleep_nxt = 1'b0;
        end else if (bus.s2p_valid) begin
          do_in_wr  = 1'b1;
          do_kick   = 1'b1;
          cnt_upd   = 1'b1;
          state_nxt = ((zl_upd == ZLIM) && (zr_upd == ZLIM)) ? SLEEP : WORK;
        end
      end
      SLEEP: begin
        if (chip_rst) begin
          state_nxt = CLEAR;
          clr_start = 1'b1;
          cnt_clr   = 1'b1;
          sleep_nxt = 1'b0;
        end else if (wake) begin
          // the ALU controller restarts itself on the falling sleep_flag, so no kick here
          do_in_wr  = 1'b1;
          cnt_upd   = 1'b1;
          sleep_nxt = 1'b0;
          state_nxt = WORK;
        end else begin
          sleep_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // FSM state and zero-run counters.
  always_ff @(posedge Sclk or negedge Clear_n) begin
    if (!Clear_n) begin
      state <= INIT;
      zl    <= 10'd0;
      zr    <= 10'd0;
    end else begin
      state <= state_nxt;
      if (cnt_clr) begin
        zl <= 10'd0;
        zr <= 10'd0;
      end else if (cnt_upd) begin
        zl <= zl_upd;
        zr <= zr_upd;
      end
    end
  end

  // Memory write strobes, addresses and data; each address advances the cycle after its write.
  always_ff @(posedge Sclk or negedge Clear_n) begin
    if (!Clear_n) begin
      bus.rj_we       <= 1'b0;
      bus.rj_waddr    <= 4'd0;
      bus.coeff_we    <= 1'b0;
      bus.coeff_waddr <= 9'd0;
      bus.in_we       <= 1'b0;
      bus.in_waddr    <= 8'd0;
      bus.wdataL      <= 16'd0;
      bus.wdataR      <= 16'd0;
    end else begin
      bus.rj_we       <= do_rj;
      bus.rj_waddr    <= bus.rj_waddr + {3'd0, bus.rj_we};
      bus.coeff_we    <= do_coeff;
      bus.coeff_waddr <= bus.coeff_waddr + {8'd0, bus.coeff_we};
      bus.in_we       <= do_in_wr | clr_wr | clr_start;
      // a chip reset restarts the sweep at 0, overriding any pending increment
      bus.in_waddr    <= clr_start ? 8'd0 : bus.in_waddr + {7'd0, bus.in_we};
      if (clr_wr || clr_start) begin
        bus.wdataL <= 16'd0;
        bus.wdataR <= 16'd0;
      end else if (do_in_wr || do_rj || do_coeff) begin
        bus.wdataL <= bus.dataL;
        bus.wdataR <= bus.dataR;
      end
    end
  end

  // ALU controller handshake: start pulse one cycle behind the input write, clear, sleep, and InReady.
  always_ff @(posedge Sclk or negedge Clear_n) begin
    if (!Clear_n) begin
      kick            <= 1'b0;
      bus.work_enable <= 1'b0;
      bus.Clear       <= 1'b1;
      bus.sleep_flag  <= 1'b0;
      bus.InReady     <= 1'b0;
    end else begin
      kick            <= do_kick;
      bus.work_enable <= kick;
      bus.Clear       <= (state_nxt == INIT) || (state_nxt == CLEAR);
      bus.InReady     <= !((state_nxt == INIT) || (state_nxt == CLEAR));
      bus.sleep_flag  <= sleep_nxt;
    end
  end

endmodule

// File: tb/tb_msdap_main_controller.sv
// Scoreboard bench for msdap_main_controller: directed stimulus pushes expected writes/pulses with their cycle.
// A negedge monitor pops and compares every rj/coeff/input write and every work_enable pulse.
// Directed checks cover reset values, InReady/Clear in INIT/CLEAR and sleep_flag around sleep/wake.
module tb_msdap_main_controller;

  typedef struct {
    int          cyc;
    int          addr;
    logic [15:0] l;
    logic [15:0] r;
    logic        clr;
  } exp_t;

  logic Sclk;
  logic Clear_n;
  logic Reset_in_n;
  msdap_main_controller_if bus();

  msdap_main_controller #(.ZERO_LIMIT(800)) dut (
    .Sclk       (Sclk),
    .Clear_n    (Clear_n),
    .Reset_in_n (Reset_in_n),
    .bus        (bus)
  );

  exp_t q_rj[$];
  exp_t q_co[$];
  exp_t q_in[$];
  int   q_we[$];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int exp_rj = 0;
  int exp_co = 0;
  int exp_in = 0;
  int c0, c1;
  exp_t mon_e;
  int   mon_c;

  initial Sclk = 1'b0;
  always #5 Sclk = ~Sclk;

  always @(posedge Sclk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input string msg);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, msg);
  endtask

  // kind: 0 = expect dropped, 1 = Rj write, 2 = coeff write, 3 = input write
  task automatic strobe(input logic [15:0] l, input logic [15:0] r, input int kind, input bit kick);
    exp_t e;
    bus.s2p_valid = 1'b1;
    bus.dataL     = l;
    bus.dataR     = r;
    e.cyc = cyc + 1;
    e.l   = l;
    e.r   = r;
    e.clr = 1'b0;
    case (kind)
      1: begin e.addr = exp_rj; exp_rj = (exp_rj + 1) % 16;  q_rj.push_back(e); end
      2: begin e.addr = exp_co; exp_co = (exp_co + 1) % 512; q_co.push_back(e); end
      3: begin
        e.addr = exp_in; exp_in = (exp_in + 1) % 256; q_in.push_back(e);
        if (kick) q_we.push_back(cyc + 2);
      end
      default: ;
    endcase
    @(negedge Sclk);
    bus.s2p_valid = 1'b0;
    @(negedge Sclk);
  endtask

  task automatic push_clears(input int base);
    exp_t e;
    for (int i = 0; i < 256; i++) begin
      e.cyc = base + 1 + i;
      e.addr = i;
      e.l = 16'd0;
      e.r = 16'd0;
      e.clr = 1'b1;
      q_in.push_back(e);
    end
    exp_in = 0;
  endtask

  // Monitor: every write strobe and start pulse must match the head of its queue, including the cycle.
  always @(negedge Sclk) begin
    if (bus.rj_we) begin
      if (q_rj.size() == 0) chk("rj_unexpected", 1'b0, $sformatf("got rj_we at cyc=%0d addr=%0d, required none", cyc, bus.rj_waddr));
      else begin
        mon_e = q_rj.pop_front();
        chk("rj_write", cyc == mon_e.cyc && bus.rj_waddr == 4'(mon_e.addr) && bus.wdataL == mon_e.l && bus.wdataR == mon_e.r,
            $sformatf("got cyc=%0d addr=%0d L=%h R=%h, required cyc=%0d addr=%0d L=%h R=%h",
                      cyc, bus.rj_waddr, bus.wdataL, bus.wdataR, mon_e.cyc, mon_e.addr, mon_e.l, mon_e.r));
      end
    end
    if (bus.coeff_we) begin
      if (q_co.size() == 0) chk("coeff_unexpected", 1'b0, $sformatf("got coeff_we at cyc=%0d addr=%0d, required none", cyc, bus.coeff_waddr));
      else begin
        mon_e = q_co.pop_front();
        chk("coeff_write", cyc == mon_e.cyc && bus.coeff_waddr == 9'(mon_e.addr) && bus.wdataL == mon_e.l && bus.wdataR == mon_e.r,
            $sformatf("got cyc=%0d addr=%0d L=%h R=%h, required cyc=%0d addr=%0d L=%h R=%h",
                      cyc, bus.coeff_waddr, bus.wdataL, bus.wdataR, mon_e.cyc, mon_e.addr, mon_e.l, mon_e.r));
      end
    end
    if (bus.in_we) begin
      if (q_in.size() == 0) chk("in_unexpected", 1'b0, $sformatf("got in_we at cyc=%0d addr=%0d, required none", cyc, bus.in_waddr));
      else begin
        mon_e = q_in.pop_front();
        chk("in_write", cyc == mon_e.cyc && bus.in_waddr == 8'(mon_e.addr) && bus.wdataL == mon_e.l &&
                        bus.wdataR == mon_e.r && bus.Clear == mon_e.clr,
            $sformatf("got cyc=%0d addr=%0d L=%h R=%h Clear=%b, required cyc=%0d addr=%0d L=%h R=%h Clear=%b",
                      cyc, bus.in_waddr, bus.wdataL, bus.wdataR, bus.Clear, mon_e.cyc, mon_e.addr, mon_e.l, mon_e.r, mon_e.clr));
      end
    end
    if (bus.work_enable) begin
      if (q_we.size() == 0) chk("we_unexpected", 1'b0, $sformatf("got work_enable at cyc=%0d, required none", cyc));
      else begin
        mon_c = q_we.pop_front();
        chk("work_enable", cyc == mon_c, $sformatf("got pulse at cyc=%0d, required cyc=%0d", cyc, mon_c));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    Clear_n       = 1'b0;
    Reset_in_n    = 1'b1;
    bus.s2p_valid = 1'b0;
    bus.dataL     = 16'd0;
    bus.dataR     = 16'd0;
    repeat (3) @(negedge Sclk);

    // reset values
    chk("reset_ctrl", bus.InReady == 0 && bus.work_enable == 0 && bus.sleep_flag == 0 && bus.Clear == 1,
        $sformatf("got InReady=%b work_enable=%b sleep=%b Clear=%b, required 0 0 0 1",
                  bus.InReady, bus.work_enable, bus.sleep_flag, bus.Clear));
    chk("reset_mem", bus.rj_we == 0 && bus.coeff_we == 0 && bus.in_we == 0 && bus.rj_waddr == 0 &&
                     bus.coeff_waddr == 0 && bus.in_waddr == 0 && bus.wdataL == 0 && bus.wdataR == 0,
        $sformatf("got we=%b%b%b addr=%0d/%0d/%0d data=%h/%h, required all zero", bus.rj_we, bus.coeff_we,
                  bus.in_we, bus.rj_waddr, bus.coeff_waddr, bus.in_waddr, bus.wdataL, bus.wdataR));

    // power-up clear of the input memory
    Clear_n = 1'b1;
    c0 = cyc;
    push_clears(c0);
    while (cyc < c0 + 100) @(negedge Sclk);
    chk("init_busy", bus.InReady == 0 && bus.Clear == 1,
        $sformatf("got InReady=%b Clear=%b, required 0 1", bus.InReady, bus.Clear));
    while (cyc < c0 + 256) @(negedge Sclk);
    strobe(16'hDEAD, 16'hBEEF, 0, 1'b0);   // lands on the last INIT cycle
    chk("init_done", bus.InReady == 1 && bus.Clear == 0,
        $sformatf("got InReady=%b Clear=%b, required 1 0", bus.InReady, bus.Clear));

    // Rj load; a chip reset pulse here must be ignored
    for (int i = 0; i < 16; i++) begin
      if (i == 5) Reset_in_n = 1'b0;
      strobe(16'(i + 1), 16'(16'h0100 + i), 1, 1'b0);
      Reset_in_n = 1'b1;
    end

    // coefficient load
    for (int i = 0; i < 512; i++) strobe(16'(i), 16'(16'hFFFF - i), 2, 1'b0);
    chk("load_ready", bus.InReady == 1 && bus.Clear == 0,
        $sformatf("got InReady=%b Clear=%b, required 1 0", bus.InReady, bus.Clear));

    // first input, then 256 more to wrap the input pointer back to 0
    strobe(16'h1234, 16'h5678, 3, 1'b1);
    for (int i = 0; i < 256; i++) strobe(16'(16'h8000 | i), 16'(i + 1), 3, 1'b1);

    // sleep entry after 800 zero stereo samples
    for (int i = 0; i < 800; i++) begin
      strobe(16'd0, 16'd0, 3, 1'b1);
      if (i == 798) chk("sleep_799", bus.sleep_flag == 0, $sformatf("got sleep_flag=%b, required 0", bus.sleep_flag));
    end
    chk("sleep_800", bus.sleep_flag == 1, $sformatf("got sleep_flag=%b, required 1", bus.sleep_flag));
    for (int i = 0; i < 5; i++) strobe(16'd0, 16'd0, 0, 1'b0);
    chk("sleep_hold", bus.sleep_flag == 1, $sformatf("got sleep_flag=%b, required 1", bus.sleep_flag));
    strobe(16'h0001, 16'h0000, 3, 1'b0);   // wake: written, no work_enable
    chk("wake", bus.sleep_flag == 0, $sformatf("got sleep_flag=%b, required 0", bus.sleep_flag));

    // zeros on one channel only never put the chip to sleep
    for (int i = 0; i < 900; i++) begin
      strobe(16'd0, 16'd5, 3, 1'b1);
      if (i % 300 == 299) chk("one_chan", bus.sleep_flag == 0, $sformatf("got sleep_flag=%b at sample %0d, required 0", bus.sleep_flag, i));
    end

    // chip reset mid-WORK, with a simultaneous strobe that must be dropped
    Reset_in_n    = 1'b0;
    bus.s2p_valid = 1'b1;
    bus.dataL     = 16'h7777;
    bus.dataR     = 16'h7777;
    c1 = cyc;
    push_clears(c1);
    @(negedge Sclk);
    Reset_in_n    = 1'b1;
    bus.s2p_valid = 1'b0;
    chk("clear_state", bus.InReady == 0 && bus.Clear == 1 && bus.sleep_flag == 0,
        $sformatf("got InReady=%b Clear=%b sleep=%b, required 0 1 0", bus.InReady, bus.Clear, bus.sleep_flag));
    for (int i = 0; i < 10; i++) begin
      if (i == 4) Reset_in_n = 1'b0;       // not sampled during CLEAR
      strobe(16'h4444, 16'h5555, 0, 1'b0);
      Reset_in_n = 1'b1;
    end
    while (cyc < c1 + 256) @(negedge Sclk);
    strobe(16'h9999, 16'h9999, 0, 1'b0);   // lands on the last CLEAR cycle
    chk("clear_done", bus.InReady == 1 && bus.Clear == 0,
        $sformatf("got InReady=%b Clear=%b, required 1 0", bus.InReady, bus.Clear));
    strobe(16'hABCD, 16'h0001, 3, 1'b1);   // first sample after CLEAR lands at address 0

    repeat (4) @(negedge Sclk);
    chk("drain_rj", q_rj.size() == 0, $sformatf("got %0d Rj writes outstanding, required 0", q_rj.size()));
    chk("drain_coeff", q_co.size() == 0, $sformatf("got %0d coeff writes outstanding, required 0", q_co.size()));
    chk("drain_in", q_in.size() == 0, $sformatf("got %0d input writes outstanding, required 0", q_in.size()));
    chk("drain_we", q_we.size() == 0, $sformatf("got %0d work_enable pulses outstanding, required 0", q_we.size()));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
